// File: rtl/mag_pkg.sv
// Shared definitions for the windowed magnitude statistics block:
// Q12.15 magnitude format and the window FSM state encoding.
package mag_pkg;

    localparam int MAG_W  = 27;
    localparam int FRAC_W = 15;

    typedef logic [MAG_W-1:0] mag_t;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } win_state_e;

endpackage

// File: rtl/mag_win_acc.sv
// Window accumulator: sample counter, running max and (with WIN_AVG_EN) running sum.
// Exposes the post-sample max/sum so the caller can capture a completed window.
module mag_win_acc
    import mag_pkg::*;
#(
    parameter int WIN_LOG2 = 4,
    parameter int MAG_W    = mag_pkg::MAG_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_i,
    input  logic                      xfer_i,
    input  logic [MAG_W-1:0]          mag_i,
    output logic                      last_o,
`ifdef WIN_AVG_EN
    output logic [MAG_W+WIN_LOG2-1:0] sum_next_o,
`endif
    output logic [MAG_W-1:0]          max_next_o
);

    localparam int                  SUM_W    = MAG_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_LAST = {WIN_LOG2{1'b1}};
    localparam logic [WIN_LOG2-1:0] CNT_ZERO = {WIN_LOG2{1'b0}};

    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [MAG_W-1:0]    max_q, max_d;
    logic                first_s;
`ifdef WIN_AVG_EN
    logic [SUM_W-1:0]    sum_q, sum_d;
`endif

    // Post-sample values; the first sample of a window loads directly.
    always_comb begin
        first_s = (cnt_q == CNT_ZERO);
        last_o  = (cnt_q == CNT_LAST);
        if (first_s) begin
            max_next_o = mag_i;
        end else if (mag_i > max_q) begin
            max_next_o = mag_i;
        end else begin
            max_next_o = max_q;
        end
`ifdef WIN_AVG_EN
        if (first_s) begin
            sum_next_o = SUM_W'(mag_i);
        end else begin
            sum_next_o = sum_q + SUM_W'(mag_i);
        end
`endif
    end

    // Next-state for counter and running statistics; clear wins over a transfer.
    always_comb begin
        cnt_d = cnt_q;
        max_d = max_q;
`ifdef WIN_AVG_EN
        sum_d = sum_q;
`endif
        if (clr_i) begin
            cnt_d = CNT_ZERO;
            max_d = {MAG_W{1'b0}};
`ifdef WIN_AVG_EN
            sum_d = {SUM_W{1'b0}};
`endif
        end else if (xfer_i) begin
            cnt_d = last_o ? CNT_ZERO : (cnt_q + WIN_LOG2'(1'b1));
            max_d = max_next_o;
`ifdef WIN_AVG_EN
            sum_d = sum_next_o;
`endif
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_ZERO;
            max_q <= {MAG_W{1'b0}};
`ifdef WIN_AVG_EN
            sum_q <= {SUM_W{1'b0}};
`endif
        end else begin
            cnt_q <= cnt_d;
            max_q <= max_d;
`ifdef WIN_AVG_EN
            sum_q <= sum_d;
`endif
        end
    end

endmodule

// File: rtl/mag_window_stats.sv
// Windowed peak/mean of a magnitude stream with a valid/ready result handshake.
// Optional macro WIN_AVG_EN builds the running sum and the avg output.
module mag_window_stats
    import mag_pkg::*;
#(
    parameter int WIN_LOG2 = 4,
    parameter int MAG_W    = mag_pkg::MAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [MAG_W-1:0] in_mag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [MAG_W-1:0] peak,
`ifdef WIN_AVG_EN
    output logic [MAG_W-1:0] avg,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    win_state_e       state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [MAG_W-1:0] peak_q;
    logic             xfer_s;
    logic             acc_clr_s;
    logic             last_s;
    logic [MAG_W-1:0] max_next_s;
`ifdef WIN_AVG_EN
    localparam int    SUM_W = MAG_W + WIN_LOG2;
    logic [SUM_W-1:0] sum_next_s;
    logic [MAG_W-1:0] avg_q;
`endif

    // A sample is dropped in the cycle it is presented together with clr.
    always_comb begin
        xfer_s    = in_valid & in_ready_q & ~clr;
        acc_clr_s = clr & (state_q == ST_ACCUM);
    end

    mag_win_acc #(
        .WIN_LOG2 (WIN_LOG2),
        .MAG_W    (MAG_W)
    ) u_acc (
        .clk        (clk),
        .rst_n      (rst),
        .clr_i      (acc_clr_s),
        .xfer_i     (xfer_s),
        .mag_i      (in_mag),
        .last_o     (last_s),
`ifdef WIN_AVG_EN
        .sum_next_o (sum_next_s),
`endif
        .max_next_o (max_next_s)
    );

    // Window FSM with registered handshake flags and result capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ACCUM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            peak_q      <= {MAG_W{1'b0}};
`ifdef WIN_AVG_EN
            avg_q       <= {MAG_W{1'b0}};
`endif
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (xfer_s && last_s) begin
                        state_q     <= ST_HOLD;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                        peak_q      <= max_next_s;
`ifdef WIN_AVG_EN
                        avg_q       <= sum_next_s[SUM_W-1:WIN_LOG2];
`endif
                    end else begin
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_q     <= ST_ACCUM;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end else begin
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_ACCUM;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign peak      = peak_q;
`ifdef WIN_AVG_EN
    assign avg       = avg_q;
`endif

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats with WIN_LOG2 = 2; avg checked when WIN_AVG_EN is defined.
module tb_mag_window_stats;

    localparam int WIN_LOG2 = 2;
    localparam int MAG_W    = 27;
    localparam logic [MAG_W-1:0] MAXV = 27'h7FFFFFF;

    logic             clk;
    logic             rst;
    logic             clr;
    logic [MAG_W-1:0] in_mag;
    logic             in_valid;
    logic             in_ready;
    logic [MAG_W-1:0] peak;
    logic [MAG_W-1:0] avg;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    mag_window_stats #(
        .WIN_LOG2 (WIN_LOG2),
        .MAG_W    (MAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_mag    (in_mag),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .peak      (peak),
`ifdef WIN_AVG_EN
        .avg       (avg),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifndef WIN_AVG_EN
    assign avg = {MAG_W{1'b0}};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_avg(input string tag, input logic [63:0] exp);
`ifdef WIN_AVG_EN
        chk(tag, 64'(avg), exp);
`else
        if (exp === 64'hFFFF_FFFF_FFFF_FFFF) $display("note: %s", tag);
`endif
    endtask

    // Four back-to-back samples with in_valid held; returns one edge after the last.
    task automatic send4(input logic [MAG_W-1:0] a, input logic [MAG_W-1:0] b,
                         input logic [MAG_W-1:0] c, input logic [MAG_W-1:0] d);
        in_valid = 1'b1;
        in_mag = a; tick();
        in_mag = b; tick();
        in_mag = c; tick();
        in_mag = d; tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_mag = '0; in_valid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_in_ready",  64'(in_ready),  64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_peak",      64'(peak),      64'd0);
        chk_avg("rst_avg", 64'd0);
        tick(); tick();
        chk("rst_hold_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
        tick();
        chk("rel_in_ready_post", 64'(in_ready), 64'd1);

        // basic window, out_ready high throughout
        out_ready = 1'b1;
        send4(27'h18000, 27'h24000, 27'h30000, 27'h1E000);
        chk("w1_out_valid", 64'(out_valid), 64'd1);
        chk("w1_in_ready",  64'(in_ready),  64'd0);
        chk("w1_peak",      64'(peak),      64'h30000);
        chk_avg("w1_avg", 64'h22800);
        in_valid = 1'b1; in_mag = MAXV;   // offered in the handshake bubble, must be ignored
        tick();
        in_valid = 1'b0;
        chk("w1_ack_out_valid", 64'(out_valid), 64'd0);
        chk("w1_ack_in_ready",  64'(in_ready),  64'd1);

        // result held under back-pressure; clr and samples in HOLD are ignored
        out_ready = 1'b0;
        send4(27'h18000, 27'h24000, 27'h30000, 27'h1E000);
        in_valid = 1'b1; in_mag = MAXV;
        for (int i = 0; i < 5; i++) begin
            clr = (i == 2) ? 1'b1 : 1'b0;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
            chk("bp_peak",      64'(peak),      64'h30000);
            chk_avg("bp_avg", 64'h22800);
            tick();
        end
        clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_last_out_valid", 64'(out_valid), 64'd1);
        tick();
        chk("bp_rel_in_ready",  64'(in_ready),  64'd1);
        chk("bp_rel_out_valid", 64'(out_valid), 64'd0);

        // clr aborts a partial window
        in_valid = 1'b1;
        in_mag = MAXV;     tick();
        in_mag = 27'h40000; tick();
        clr = 1'b1; in_mag = MAXV; tick();
        clr = 1'b0;
        chk("clr_out_valid", 64'(out_valid), 64'd0);
        in_mag = 27'h08000; tick(); tick(); tick();
        chk("clr_not_done", 64'(out_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        chk("clr_out_valid_done", 64'(out_valid), 64'd1);
        chk("clr_peak",           64'(peak),      64'h08000);
        chk_avg("clr_avg", 64'h08000);
        tick();

        // extreme values, equal maxima
        send4(27'h0, MAXV, MAXV, 27'h0);
        chk("ext_out_valid", 64'(out_valid), 64'd1);
        chk("ext_peak",      64'(peak),      64'h7FFFFFF);
        chk_avg("ext_avg", 64'h3FFFFFF);
        tick();

        // gapped input after a large window: first sample must not see stale max
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_mag   = (i == 3) ? 27'd5 : 27'(i + 1);
            tick();
            in_valid = 1'b0;
            if (i < 3) begin
                chk("gap_pending", 64'(out_valid), 64'd0);
                tick();
            end
        end
        chk("gap_out_valid", 64'(out_valid), 64'd1);
        chk("gap_peak",      64'(peak),      64'd5);
        chk_avg("gap_avg", 64'd2);
        tick();

        // asynchronous reset mid-window
        send4(27'h30000, 27'h30000, 27'h30000, 27'h30000);
        tick();
        in_valid = 1'b1; in_mag = 27'h30000;
        tick(); tick(); tick();
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("arst_peak",      64'(peak),      64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_in_ready",  64'(in_ready),  64'd0);
        chk_avg("arst_avg", 64'd0);
        #1 rst = 1'b1;
        tick();
        chk("arst_rel_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_mag = 27'h18000;
        tick();
        chk("arst_cnt_cleared", 64'(out_valid), 64'd0);
        tick(); tick(); tick();
        in_valid = 1'b0;
        chk("arst_out_valid_done", 64'(out_valid), 64'd1);
        chk("arst_peak_new",       64'(peak),      64'h18000);
        chk_avg("arst_avg_new", 64'h18000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
